// File: rtl/load_scoreboard.sv
// -----------------------------------------------------------------------------
// load_scoreboard
//
// Purpose:
//   Tracks destination registers of in-flight long-latency writers (loads,
//   multi-cycle ops) that the EX-stage forwarding network cannot cover. One
//   pending counter is kept per architectural register (x0 never tracked).
//   Decode reserves a slot when it issues a long-latency writer. Writeback
//   (done) and squash (kill) release slots. Fetch/decode are stalled while the
//   decoding instruction reads a pending register, or when its destination
//   counter is saturated.
//
// Ports:
//   clk            core clock, rising edge
//   rst            asynchronous active-low reset
//   issue_valid    decode holds a valid instruction
//   issue_long     decoding instruction is a long-latency writer
//   issue_rd       destination of the decoding instruction
//   use_rs1/2      decoding instruction reads rs1/rs2
//   Rs1_D/Rs2_D    source registers in decode
//   done_valid     long-latency result reaches writeback
//   done_rd        destination of the completing result
//   kill_valid     a reserved long-latency instruction is squashed
//   kill_rd        destination of the squashed instruction
//   StallF/StallD  hold PC / hold IF-ID (combinational)
//   FlushE         bubble into ID-EX (combinational)
//   busy_any       registered: some counter is non-zero
//   sb_err         sticky underflow/overflow flag
//   stall_cycles   saturating count of cycles with StallD=1
// -----------------------------------------------------------------------------
module load_scoreboard #(
   parameter int NREG   = 32,
   parameter int CNT_W  = 2,
   parameter int PERF_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              issue_valid,
   input  logic              issue_long,
   input  logic [4:0]        issue_rd,
   input  logic              use_rs1,
   input  logic              use_rs2,
   input  logic [4:0]        Rs1_D,
   input  logic [4:0]        Rs2_D,
   input  logic              done_valid,
   input  logic [4:0]        done_rd,
   input  logic              kill_valid,
   input  logic [4:0]        kill_rd,
   output logic              StallF,
   output logic              StallD,
   output logic              FlushE,
   output logic              busy_any,
   output logic              sb_err,
   output logic [PERF_W-1:0] stall_cycles
);

   localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1'b1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};

   logic [CNT_W-1:0]  cnt_q [NREG];
   logic [CNT_W-1:0]  cnt_d [NREG];
   logic              busy_any_q;
   logic              busy_any_d;
   logic              sb_err_q;
   logic              sb_err_d;
   logic [PERF_W-1:0] stall_cycles_q;
   logic [PERF_W-1:0] stall_cycles_d;

   logic              rs1_hit;
   logic              rs2_hit;
   logic              sat_hit;
   logic              stall;
   logic              inc_en;
   logic              done_en;
   logic              kill_en;
   logic              err_now;

   // Per-register scratch values used inside the counter update loop
   logic              up_s;
   logic [1:0]        dn_s;
   logic [CNT_W:0]    sum_s;
   logic [CNT_W:0]    dn_ext_s;
   logic [CNT_W:0]    diff_s;

   // Hazard detection: source hits, saturation hit and the combined stall
   always_comb begin
      rs1_hit = 1'b0;
      rs2_hit = 1'b0;
      sat_hit = 1'b0;
      stall   = 1'b0;
      done_en = done_valid & (done_rd != 5'd0);
      kill_en = kill_valid & (kill_rd != 5'd0);
      if (rst) begin
         // A value that completes in writeback this cycle and is the last
         // outstanding write is forwarded from W, so it is not a hit.
         rs1_hit = use_rs1 & issue_valid & (Rs1_D != 5'd0) &
                   (cnt_q[Rs1_D] != CNT_ZERO) &
                   ~(done_valid & (done_rd == Rs1_D) & (cnt_q[Rs1_D] == CNT_ONE));
         rs2_hit = use_rs2 & issue_valid & (Rs2_D != 5'd0) &
                   (cnt_q[Rs2_D] != CNT_ZERO) &
                   ~(done_valid & (done_rd == Rs2_D) & (cnt_q[Rs2_D] == CNT_ONE));
         // A full counter only blocks issue when no release frees a slot now.
         sat_hit = issue_valid & issue_long & (issue_rd != 5'd0) &
                   (cnt_q[issue_rd] == CNT_MAX) &
                   ~((done_en & (done_rd == issue_rd)) |
                     (kill_en & (kill_rd == issue_rd)));
         stall   = rs1_hit | rs2_hit | sat_hit;
      end else begin
         stall   = 1'b0;
      end
      inc_en = issue_valid & issue_long & (issue_rd != 5'd0) & ~stall;
   end

   assign StallF = stall;
   assign StallD = stall;
   assign FlushE = stall;

   // Next-state counters: cnt + inc - decs with clamping and error detection
   always_comb begin
      err_now    = 1'b0;
      busy_any_d = 1'b0;
      up_s       = 1'b0;
      dn_s       = 2'd0;
      sum_s      = {(CNT_W+1){1'b0}};
      dn_ext_s   = {(CNT_W+1){1'b0}};
      diff_s     = {(CNT_W+1){1'b0}};
      cnt_d[0]   = CNT_ZERO;
      for (int r = 1; r < NREG; r++) begin
         up_s     = inc_en & (issue_rd == 5'(r));
         dn_s     = {1'b0, done_en & (done_rd == 5'(r))} +
                    {1'b0, kill_en & (kill_rd == 5'(r))};
         sum_s    = {1'b0, cnt_q[r]} + {{CNT_W{1'b0}}, up_s};
         dn_ext_s = (CNT_W+1)'(dn_s);
         diff_s   = sum_s - dn_ext_s;
         if (dn_ext_s > sum_s) begin
            cnt_d[r] = CNT_ZERO;
            err_now  = 1'b1;
         end else if (diff_s > {1'b0, CNT_MAX}) begin
            cnt_d[r] = CNT_MAX;
            err_now  = 1'b1;
         end else begin
            cnt_d[r] = diff_s[CNT_W-1:0];
         end
         busy_any_d = busy_any_d | (cnt_d[r] != CNT_ZERO);
      end
   end

   // Sticky error and saturating stall-cycle counter next state
   always_comb begin
      sb_err_d = sb_err_q | err_now;
      if (stall && (stall_cycles_q != PERF_MAX)) begin
         stall_cycles_d = stall_cycles_q + PERF_W'(1'b1);
      end else begin
         stall_cycles_d = stall_cycles_q;
      end
   end

   // State registers with asynchronous active-low clear
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < NREG; r++) begin
            cnt_q[r] <= CNT_ZERO;
         end
         busy_any_q     <= 1'b0;
         sb_err_q       <= 1'b0;
         stall_cycles_q <= {PERF_W{1'b0}};
      end else begin
         for (int r = 0; r < NREG; r++) begin
            cnt_q[r] <= cnt_d[r];
         end
         busy_any_q     <= busy_any_d;
         sb_err_q       <= sb_err_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign busy_any     = busy_any_q;
   assign sb_err       = sb_err_q;
   assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_load_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_load_scoreboard
//
// Self-checking bench for load_scoreboard. A reference model holds plain
// integer pending counts per register and derives stall, busy, error and the
// stall-cycle count from the scoreboard rules. A negedge compare process checks
// every cycle; directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_load_scoreboard;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        issue_valid, issue_long, use_rs1, use_rs2;
   logic        done_valid, kill_valid;
   logic [4:0]  issue_rd, Rs1_D, Rs2_D, done_rd, kill_rd;
   logic        StallF, StallD, FlushE, busy_any, sb_err;
   logic [15:0] stall_cycles;

   int n_assert = 0;
   int n_fail   = 0;
   bit cmp_en   = 1'b0;

   // Reference model state
   int cnt_m [32];
   bit busy_m;
   bit err_m;
   int perf_m;

   load_scoreboard #(.NREG(32), .CNT_W(2), .PERF_W(16)) dut (
      .clk(clk), .rst(rst),
      .issue_valid(issue_valid), .issue_long(issue_long), .issue_rd(issue_rd),
      .use_rs1(use_rs1), .use_rs2(use_rs2), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D),
      .done_valid(done_valid), .done_rd(done_rd),
      .kill_valid(kill_valid), .kill_rd(kill_rd),
      .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
      .busy_any(busy_any), .sb_err(sb_err), .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_assert++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit src_hit(input bit use_it, input int rs);
      return use_it && issue_valid && rs != 0 && cnt_m[rs] != 0 &&
             !(done_valid && done_rd == rs && cnt_m[rs] == 1);
   endfunction

   function automatic bit model_stall();
      bit sat;
      if (!rst) return 1'b0;
      sat = issue_valid && issue_long && issue_rd != 0 && cnt_m[issue_rd] == 3 &&
            !((done_valid && done_rd == issue_rd) || (kill_valid && kill_rd == issue_rd));
      return src_hit(use_rs1, int'(Rs1_D)) || src_hit(use_rs2, int'(Rs2_D)) || sat;
   endfunction

   task automatic model_clear();
      for (int r = 0; r < 32; r++) cnt_m[r] = 0;
      busy_m = 1'b0;
      err_m  = 1'b0;
      perf_m = 0;
   endtask

   // Model: asynchronous clear
   always @(negedge rst) model_clear();

   // Model: per-edge update from the scoreboard rules
   always @(posedge clk) begin
      bit st;
      int n;
      if (!rst) begin
         model_clear();
      end else begin
         st = model_stall();
         busy_m = 1'b0;
         for (int r = 1; r < 32; r++) begin
            n = cnt_m[r];
            if (issue_valid && issue_long && issue_rd == r && !st) n = n + 1;
            if (done_valid && done_rd == r) n = n - 1;
            if (kill_valid && kill_rd == r) n = n - 1;
            if (n < 0) begin n = 0; err_m = 1'b1; end
            if (n > 3) begin n = 3; err_m = 1'b1; end
            cnt_m[r] = n;
            if (n != 0) busy_m = 1'b1;
         end
         if (st && perf_m < 65535) perf_m = perf_m + 1;
      end
   end

   // Compare process: DUT against the model every cycle
   always @(negedge clk) begin
      if (cmp_en) begin
         check("StallF", int'(StallF), int'(model_stall()));
         check("StallD", int'(StallD), int'(model_stall()));
         check("FlushE", int'(FlushE), int'(model_stall()));
         check("busy_any", int'(busy_any), int'(busy_m));
         check("sb_err", int'(sb_err), int'(err_m));
         check("stall_cycles", int'(stall_cycles), perf_m);
      end
   end

   task automatic set_idle();
      issue_valid = 1'b0; issue_long = 1'b0; issue_rd = 5'd0;
      use_rs1 = 1'b0; use_rs2 = 1'b0; Rs1_D = 5'd0; Rs2_D = 5'd0;
      done_valid = 1'b0; done_rd = 5'd0; kill_valid = 1'b0; kill_rd = 5'd0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   task automatic issue(input logic [4:0] rd);
      issue_valid = 1'b1; issue_long = 1'b1; issue_rd = rd;
   endtask

   initial begin
      set_idle();
      #2 rst = 1'b0;
      #1;
      // Reset state
      check("rst_stall", int'(StallD), 0);
      check("rst_busy", int'(busy_any), 0);
      check("rst_err", int'(sb_err), 0);
      check("rst_perf", int'(stall_cycles), 0);
      tick();
      rst = 1'b1;
      cmp_en = 1'b1;
      tick();
      check("idle_busy", int'(busy_any), 0);
      check("idle_stall", int'(StallF), 0);

      // Load-use stall released by writeback bypass
      issue(5'd5);
      tick();
      set_idle();
      issue_valid = 1'b1; use_rs1 = 1'b1; Rs1_D = 5'd5;
      #1 check("lu_stall", int'(StallD), 1);
      check("lu_busy", int'(busy_any), 1);
      tick(); tick(); tick();
      done_valid = 1'b1; done_rd = 5'd5;
      #1 check("lu_bypass", int'(StallD), 0);
      tick();
      set_idle();
      #1;
      check("lu_cnt5", int'(dut.cnt_q[5]), 0);
      check("lu_busy_after", int'(busy_any), 0);
      check("lu_perf", int'(stall_cycles), 3);
      check("lu_model_perf", perf_m, 3);

      // Saturation on rd=7
      do_reset();
      issue(5'd7);
      tick(); tick(); tick();
      check("sat_cnt7", int'(dut.cnt_q[7]), 3);
      check("sat_model_cnt7", cnt_m[7], 3);
      #1 check("sat_stall", int'(StallD), 1);
      tick();
      check("sat_perf", int'(stall_cycles), 1);
      done_valid = 1'b1; done_rd = 5'd7;
      #1 check("sat_free", int'(StallD), 0);
      tick();
      set_idle();
      check("sat_cnt7_after", int'(dut.cnt_q[7]), 3);
      check("sat_err", int'(sb_err), 0);

      // Simultaneous done + kill on rd=9
      do_reset();
      issue(5'd9);
      tick(); tick();
      set_idle();
      check("rel_cnt9_pre", int'(dut.cnt_q[9]), 2);
      done_valid = 1'b1; done_rd = 5'd9; kill_valid = 1'b1; kill_rd = 5'd9;
      tick();
      set_idle();
      #1;
      check("rel_cnt9", int'(dut.cnt_q[9]), 0);
      check("rel_busy", int'(busy_any), 0);
      check("rel_err", int'(sb_err), 0);

      // Underflow on rd=12
      done_valid = 1'b1; done_rd = 5'd12;
      tick();
      set_idle();
      check("uf_cnt12", int'(dut.cnt_q[12]), 0);
      check("uf_err", int'(sb_err), 1);
      tick(); tick(); tick();
      check("uf_err_sticky", int'(sb_err), 1);

      // x0 is never tracked
      do_reset();
      check("x0_err_cleared", int'(sb_err), 0);
      issue(5'd0);
      use_rs1 = 1'b1; Rs1_D = 5'd0;
      #1 check("x0_stall", int'(StallD), 0);
      tick();
      set_idle();
      #1 check("x0_busy", int'(busy_any), 0);

      // Asynchronous reset in the middle of a stall
      issue(5'd3);
      tick();
      set_idle();
      issue_valid = 1'b1; use_rs2 = 1'b1; Rs2_D = 5'd3;
      #1 check("ar_stall", int'(StallD), 1);
      rst = 1'b0;
      #1;
      check("ar_stall_drop", int'(StallD), 0);
      check("ar_cnt3", int'(dut.cnt_q[3]), 0);
      check("ar_busy", int'(busy_any), 0);
      tick();
      set_idle();
      rst = 1'b1;

      // Randomized segments
      for (int seg = 0; seg < 6; seg++) begin
         do_reset();
         for (int c = 0; c < 400; c++) begin
            issue_valid = ($urandom_range(0, 3) != 0);
            issue_long  = $urandom_range(0, 1);
            issue_rd    = 5'($urandom_range(0, 4));
            use_rs1     = $urandom_range(0, 1);
            use_rs2     = $urandom_range(0, 1);
            Rs1_D       = 5'($urandom_range(0, 4));
            Rs2_D       = 5'($urandom_range(0, 4));
            done_valid  = ($urandom_range(0, 2) == 0);
            done_rd     = 5'($urandom_range(0, 4));
            kill_valid  = ($urandom_range(0, 5) == 0);
            kill_rd     = 5'($urandom_range(0, 4));
            tick();
         end
         set_idle();
      end
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
